mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage directly downstream of EX in the RV32I 5-stage core.
- Holds the EX/MEM register and runs RV32I loads and stores over a ready/valid data-memory port, including byte and halfword alignment and load extension.
- Drives the MEM/WB register feeding write-back, and raises a stall to upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT, 255, number of cycles dmem_req may wait for dmem_ready before the access is abandoned as a fault (0 = timeout disabled).

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge, 0 = reset.
- ex_valid  in  1  EX result valid.
- ex_alu_result  in  32  ALU result, or effective address for loads/stores.
- ex_rs2_val  in  32  store data.
- ex_rd  in  5  destination register.
- ex_funct3  in  3  load/store width and sign.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_reg_write  in  1  instruction writes rd.
- mem_stall  out  1  upstream must hold EX and earlier stages (combinational).
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  replicated store data.
- dmem_wstrb  out  4  byte enables.
- dmem_ready  in  1  access accepted/completed this cycle.
- dmem_rdata  in  32  read word, valid when dmem_ready=1.
- wb_valid  out  1  MEM/WB entry valid.
- wb_rd  out  5  destination register.
- wb_data  out  32  write-back value.
- wb_reg_write  out  1  register file write enable.
- mem_fault  out  1  retiring entry faulted (one-cycle pulse, aligned with wb_valid).
- mem_fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal funct3.
- mem_fault_addr  out  32  full byte address of the faulting access.

Behaviour:
- **Reset**
  - Clears both the M register and the MEM/WB register; FSM goes to IDLE and the timeout counter to 0.
  - All outputs are 0 from the first edge with reset=0 onward.
  - Reset mid-access: dmem_req drops after that edge and the request is abandoned; memory must tolerate this.
- **M register**
  - Loads from EX on every edge where mem_stall=0; holds while mem_stall=1.
- **Non-memory entry**
  - Written to MEM/WB on the next edge: wb_data = alu_result, wb_reg_write = ex_reg_write & valid.
  - One-cycle latency; never stalls.
- **Alignment checks** (combinational on the M entry)
  - Misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - Illegal funct3: loads 011/110/111; stores other than 000/001/010.
  - On either: no dmem_req; retire on the next edge with wb_reg_write=0, mem_fault=1 and the matching cause.
- **FSM**
  - IDLE: M holds a valid, legal memory op → dmem_req=1 combinationally, enter BUSY.
  - BUSY: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb held stable until dmem_ready.
  - mem_stall = req & ~dmem_ready. A zero-wait memory (ready in the request cycle) produces no stall.
  - On the dmem_ready edge, the result retires into MEM/WB and M loads the next EX entry.
  - If the next M entry is also a memory op, dmem_req stays high with the new address (back-to-back accesses allowed).
  - While stalled, MEM/WB receives a bubble: wb_valid=0, wb_reg_write=0.
- **Timeout**
  - Counter increments each cycle with req=1 and ready=0.
  - If ready has not arrived after TIMEOUT request cycles, the entry retires on that edge with cause 10 and wb_reg_write=0; counter resets.
  - The counter is reset on every completion.
- **Stores**
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111, wdata = rs2.
  - wb_reg_write=0.
- **Loads**
  - Byte/half selected by addr[1:0] from dmem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - wb_data captured on the ready edge.
- **Simultaneous ready and timeout**
  - ready wins.

Decomposition:
- Package rv_mem_pkg:
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW).
  - Fault cause codes.
  - FSM state encoding.
- One combinational sub-module, load_store_align:
  - Inputs: funct3, addr[1:0], rs2, rdata.
  - Outputs: wstrb, wdata, load result, misaligned, illegal.

Test Plan:
- **Zero-wait LW:** dmem_ready=1 in the request cycle, addr 0x100 → no stall; next edge wb_data=dmem_rdata, wb_reg_write=1.
- **SB with wait:** addr 0x103, rs2=0xA5, ready after 3 cycles → wstrb=1000, wdata=0xA5A5A5A5; mem_stall=1 for 3 cycles; wb_reg_write=0.
- **LB and LHU extension:** rdata=0x80F0_7F80, addr 0x202: LB → 0xFFFFFFF0; LHU → 0x000080F0.
- **Misaligned LH:** addr 0x301 → no dmem_req; mem_fault=1, cause 01, fault_addr 0x301, wb_reg_write=0.
- **Timeout:** TIMEOUT=4, ready held 0 → req high for exactly 4 cycles, then mem_fault cause 10; the next instruction proceeds.
- **Reset mid-access:** reset=0 during BUSY → dmem_req=0 and wb_valid=0 after the edge; after release, a back-to-back LW,SW pair completes in order with req continuously high.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared constants for the RV32I memory stage: funct3 encodings, fault causes, FSM states.
package rv_mem_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores, load extraction/extension, and width legality checks.
module load_store_align
   import rv_mem_pkg::*;
(
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_addr,
   input  logic            i_is_store,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [XLEN-1:0] i_rdata,
   output logic [3:0]      o_wstrb_c,
   output logic [XLEN-1:0] o_wdata_c,
   output logic [XLEN-1:0] o_load_c,
   output logic            o_misaligned_c,
   output logic            o_illegal_c
);

   logic [15:0] w_shift;

   always_comb begin
      w_shift        = 16'(i_rdata >> {i_addr, 3'b000});
      o_wstrb_c      = 4'b0000;
      o_wdata_c      = '0;
      o_load_c       = '0;
      o_misaligned_c = 1'b0;
      o_illegal_c    = 1'b0;
      if (i_is_store) begin
         case (i_funct3)
            F3_SB: begin
               o_wstrb_c = 4'b0001 << i_addr;
               o_wdata_c = {4{i_rs2[7:0]}};
            end
            F3_SH: begin
               o_wstrb_c      = 4'b0011 << i_addr;
               o_wdata_c      = {2{i_rs2[15:0]}};
               o_misaligned_c = i_addr[0];
            end
            F3_SW: begin
               o_wstrb_c      = 4'b1111;
               o_wdata_c      = i_rs2;
               o_misaligned_c = |i_addr;
            end
            default: o_illegal_c = 1'b1;
         endcase
      end else begin
         case (i_funct3)
            F3_LB:  o_load_c = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_LBU: o_load_c = {24'h0, w_shift[7:0]};
            F3_LH: begin
               o_load_c       = {{16{w_shift[15]}}, w_shift};
               o_misaligned_c = i_addr[0];
            end
            F3_LHU: begin
               o_load_c       = {16'h0, w_shift};
               o_misaligned_c = i_addr[0];
            end
            F3_LW: begin
               o_load_c       = i_rdata;
               o_misaligned_c = |i_addr;
            end
            default: o_illegal_c = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: EX/MEM register, ready/valid data-memory access with timeout, MEM/WB register.
module mem_stage
   import rv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_alu_result,
   input  logic [XLEN-1:0] ex_rs2_val,
   input  logic [4:0]      ex_rd,
   input  logic [2:0]      ex_funct3,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic            ex_reg_write,
   output logic            mem_stall,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_wstrb,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            wb_reg_write,
   output logic            mem_fault,
   output logic [1:0]      mem_fault_cause,
   output logic [XLEN-1:0] mem_fault_addr
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic            r_m_valid, r_m_read, r_m_write, r_m_regw;
   logic [XLEN-1:0] r_m_addr, r_m_rs2;
   logic [4:0]      r_m_rd;
   logic [2:0]      r_m_funct3;
   state_e          r_state;
   logic [TW-1:0]   r_tcnt;
   logic            r_wb_valid, r_wb_regw, r_fault;
   logic [4:0]      r_wb_rd;
   logic [XLEN-1:0] r_wb_data, r_fault_addr;
   logic [1:0]      r_cause;

   logic [3:0]      w_wstrb;
   logic [XLEN-1:0] w_wdata, w_load;
   logic            w_mis, w_ill, w_is_mem, w_bad, w_req, w_timeout, w_stall;

   load_store_align u_align (
      .i_funct3       (r_m_funct3),
      .i_addr         (r_m_addr[1:0]),
      .i_is_store     (r_m_write),
      .i_rs2          (r_m_rs2),
      .i_rdata        (dmem_rdata),
      .o_wstrb_c      (w_wstrb),
      .o_wdata_c      (w_wdata),
      .o_load_c       (w_load),
      .o_misaligned_c (w_mis),
      .o_illegal_c    (w_ill)
   );

   assign w_is_mem  = r_m_valid & (r_m_read | r_m_write);
   assign w_bad     = w_is_mem & (w_mis | w_ill);
   assign w_req     = w_is_mem & ~w_mis & ~w_ill;
   // Ready on the final allowed cycle beats the timeout.
   assign w_timeout = (TIMEOUT != 0) & w_req & ~dmem_ready & (r_tcnt == TW'(TIMEOUT - 1));
   assign w_stall   = w_req & ~dmem_ready & ~w_timeout;

   assign mem_stall  = w_stall;
   assign dmem_req   = w_req;
   assign dmem_we    = w_req & r_m_write;
   assign dmem_addr  = w_req ? {r_m_addr[XLEN-1:2], 2'b00} : '0;
   assign dmem_wdata = dmem_we ? w_wdata : '0;
   assign dmem_wstrb = dmem_we ? w_wstrb : 4'b0000;

   // EX/MEM register: advances whenever the stage is not waiting on memory.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_m_valid  <= 1'b0;
         r_m_addr   <= '0;
         r_m_rs2    <= '0;
         r_m_rd     <= '0;
         r_m_funct3 <= '0;
         r_m_read   <= 1'b0;
         r_m_write  <= 1'b0;
         r_m_regw   <= 1'b0;
      end else if (!w_stall) begin
         r_m_valid  <= ex_valid;
         r_m_addr   <= ex_alu_result;
         r_m_rs2    <= ex_rs2_val;
         r_m_rd     <= ex_rd;
         r_m_funct3 <= ex_funct3;
         r_m_read   <= ex_mem_read;
         r_m_write  <= ex_mem_write;
         r_m_regw   <= ex_reg_write;
      end
   end

   // Access FSM: BUSY while a request waits for ready; r_tcnt counts waited cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_tcnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_stall) begin
                  r_state <= ST_BUSY;
                  r_tcnt  <= TW'(1);
               end else begin
                  r_tcnt  <= '0;
               end
            end
            ST_BUSY: begin
               if (!w_stall) begin
                  r_state <= ST_IDLE;
                  r_tcnt  <= '0;
               end else begin
                  r_tcnt  <= r_tcnt + TW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tcnt  <= '0;
            end
         endcase
      end
   end

   // MEM/WB register: bubble while stalled, otherwise retire the M entry.
   always_ff @(posedge clk) begin
      if (!reset || w_stall || !r_m_valid) begin
         r_wb_valid   <= 1'b0;
         r_wb_rd      <= '0;
         r_wb_data    <= '0;
         r_wb_regw    <= 1'b0;
         r_fault      <= 1'b0;
         r_cause      <= CAUSE_NONE;
         r_fault_addr <= '0;
      end else begin
         r_wb_valid <= 1'b1;
         r_wb_rd    <= r_m_rd;
         if (w_bad || w_timeout) begin
            r_wb_data    <= '0;
            r_wb_regw    <= 1'b0;
            r_fault      <= 1'b1;
            r_cause      <= w_timeout ? CAUSE_TIMEOUT : (w_ill ? CAUSE_ILLEGAL : CAUSE_MISALIGN);
            r_fault_addr <= r_m_addr;
         end else begin
            r_wb_data    <= (w_req && !r_m_write) ? w_load : r_m_addr;
            r_wb_regw    <= r_m_regw & ~(w_req & r_m_write);
            r_fault      <= 1'b0;
            r_cause      <= CAUSE_NONE;
            r_fault_addr <= '0;
         end
      end
   end

   assign wb_valid        = r_wb_valid;
   assign wb_rd           = r_wb_rd;
   assign wb_data         = r_wb_data;
   assign wb_reg_write    = r_wb_regw;
   assign mem_fault       = r_fault;
   assign mem_fault_cause = r_cause;
   assign mem_fault_addr  = r_fault_addr;

endmodule
